// File: rtl/date_edit_ctrl_if.sv
// Front-panel edit bus: button/tick/calendar inputs toward the edit sequencer
// and the field, gating, blink and counter pulse outputs back from it.
interface date_edit_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [4:0] day_value;
  logic [3:0] month_value;
  logic       leap;
  logic [1:0] field;
  logic       run_en;
  logic       blink;
  logic       day_inc;
  logic       day_dec;
  logic       mon_inc;
  logic       mon_dec;
  logic       year_inc;
  logic       year_dec;

  modport master (
    output tick, btn_mode, btn_up, btn_down, day_value, month_value, leap,
    input  field, run_en, blink, day_inc, day_dec, mon_inc, mon_dec,
           year_inc, year_dec
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, day_value, month_value, leap,
    output field, run_en, blink, day_inc, day_dec, mon_inc, mon_dec,
           year_inc, year_dec
  );
endinterface

// File: rtl/date_edit_ctrl.sv
// Calendar edit sequencer: mode/up/down buttons to inc/dec pulses with auto-repeat,
// day clamping after month/year edits, inactivity timeout and field blink.
module date_edit_ctrl #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 10000,
  parameter int BLINK_HALF   = 250
) (
  input logic             clk,
  input logic             rst_n,
  date_edit_ctrl_if.slave bus
);

  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam int P_DI = 0;
  localparam int P_DD = 1;
  localparam int P_MI = 2;
  localparam int P_MD = 3;
  localparam int P_YI = 4;
  localparam int P_YD = 5;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    E_DAY   = 3'd1,
    E_MON   = 3'd2,
    E_YEAR  = 3'd3,
    CL_WAIT = 3'd4,
    CL_CHK  = 3'd5
  } state_t;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                         days_in_month = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:      days_in_month = 5'd30;
      default:                      days_in_month = 5'd31;
    endcase
  endfunction

  function automatic state_t next_edit(input state_t s);
    case (s)
      E_DAY:   next_edit = E_MON;
      E_MON:   next_edit = E_YEAR;
      default: next_edit = RUN;
    endcase
  endfunction

  state_t          state_r, state_nx_s, ret_r, ret_nx_s;
  logic            mode_q_r, up_q_r, down_q_r;
  logic [HW-1:0]   hold_r, hold_nx_s;
  logic [IW-1:0]   idle_r, idle_nx_s;
  logic [BW-1:0]   blink_cnt_r, blink_cnt_nx_s;
  logic            blink_r, blink_nx_s;
  logic [1:0]      field_r, field_nx_s;
  logic            run_en_r;
  logic [5:0]      pulse_r, pulse_nx_s;
  logic            inc_s, dec_s;

  logic mode_e_s, up_e_s, down_e_s, any_btn_s, one_held_s, fresh_s, fire_s;
  logic is_edit_s, timeout_s;

  assign mode_e_s   = bus.btn_mode & ~mode_q_r;
  assign up_e_s     = bus.btn_up & ~up_q_r;
  assign down_e_s   = bus.btn_down & ~down_q_r;
  assign any_btn_s  = bus.btn_mode | bus.btn_up | bus.btn_down;
  assign one_held_s = bus.btn_up ^ bus.btn_down;
  // A fresh up/down edge restarts the hold count (covers direction changes).
  assign fresh_s    = up_e_s | down_e_s;
  assign fire_s     = bus.tick & one_held_s & ~fresh_s & (hold_r == HW'(REPEAT_DELAY - 1));
  assign is_edit_s  = (state_r == E_DAY) | (state_r == E_MON) | (state_r == E_YEAR);
  assign timeout_s  = is_edit_s & bus.tick & ~any_btn_s & (idle_r == IW'(TIMEOUT - 1));

  // Next-state, hold counter and pulse decode.
  always_comb begin
    state_nx_s = state_r;
    ret_nx_s   = ret_r;
    hold_nx_s  = hold_r;
    pulse_nx_s = 6'b000000;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    case (state_r)
      RUN: begin
        hold_nx_s = '0;
        if (mode_e_s) begin
          state_nx_s = E_DAY;
        end else begin
          state_nx_s = RUN;
        end
      end
      E_DAY, E_MON, E_YEAR: begin
        if (timeout_s) begin
          state_nx_s = RUN;
          hold_nx_s  = '0;
        end else if (mode_e_s) begin
          state_nx_s = next_edit(state_r);
          hold_nx_s  = '0;
        end else begin
          if (!one_held_s) begin
            hold_nx_s = '0;
          end else if (fresh_s) begin
            hold_nx_s = bus.tick ? HW'(1) : HW'(0);
          end else if (fire_s) begin
            hold_nx_s = HW'(REPEAT_DELAY - REPEAT_RATE);
          end else if (bus.tick) begin
            hold_nx_s = hold_r + HW'(1);
          end else begin
            hold_nx_s = hold_r;
          end
          inc_s = one_held_s & bus.btn_up & (up_e_s | fire_s);
          dec_s = one_held_s & bus.btn_down & (down_e_s | fire_s);
          case (state_r)
            E_DAY: begin
              pulse_nx_s[P_DI] = inc_s;
              pulse_nx_s[P_DD] = dec_s;
            end
            E_MON: begin
              pulse_nx_s[P_MI] = inc_s;
              pulse_nx_s[P_MD] = dec_s;
            end
            E_YEAR: begin
              pulse_nx_s[P_YI] = inc_s;
              pulse_nx_s[P_YD] = dec_s;
            end
            default: pulse_nx_s = 6'b000000;
          endcase
          // Month and year edits may leave the day beyond the new month length.
          if ((state_r != E_DAY) && (inc_s || dec_s)) begin
            state_nx_s = CL_WAIT;
            ret_nx_s   = state_r;
          end else begin
            state_nx_s = state_r;
          end
        end
      end
      CL_WAIT: begin
        hold_nx_s  = '0;
        state_nx_s = CL_CHK;
      end
      CL_CHK: begin
        hold_nx_s = '0;
        if (bus.day_value > days_in_month(bus.month_value, bus.leap)) begin
          pulse_nx_s[P_DD] = 1'b1;
          state_nx_s       = CL_WAIT;
        end else begin
          state_nx_s = ret_r;
        end
      end
      default: begin
        state_nx_s = RUN;
        hold_nx_s  = '0;
      end
    endcase
  end

  // Idle, blink and field decode driven from the next state.
  always_comb begin
    idle_nx_s      = idle_r;
    blink_cnt_nx_s = blink_cnt_r;
    blink_nx_s     = blink_r;
    field_nx_s     = field_r;
    if ((state_nx_s == RUN) || any_btn_s) begin
      idle_nx_s = '0;
    end else if (is_edit_s && bus.tick) begin
      idle_nx_s = idle_r + IW'(1);
    end else begin
      idle_nx_s = idle_r;
    end
    if (state_nx_s == RUN) begin
      blink_cnt_nx_s = '0;
      blink_nx_s     = 1'b0;
    end else if (is_edit_s && bus.tick) begin
      if (blink_cnt_r == BW'(BLINK_HALF - 1)) begin
        blink_cnt_nx_s = '0;
        blink_nx_s     = ~blink_r;
      end else begin
        blink_cnt_nx_s = blink_cnt_r + BW'(1);
        blink_nx_s     = blink_r;
      end
    end else begin
      blink_cnt_nx_s = blink_cnt_r;
      blink_nx_s     = blink_r;
    end
    case (state_nx_s)
      RUN:     field_nx_s = 2'd0;
      E_DAY:   field_nx_s = 2'd1;
      E_MON:   field_nx_s = 2'd2;
      E_YEAR:  field_nx_s = 2'd3;
      default: field_nx_s = field_r;
    endcase
  end

  // State, counters and registered outputs; button history resets high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      ret_r       <= RUN;
      mode_q_r    <= 1'b1;
      up_q_r      <= 1'b1;
      down_q_r    <= 1'b1;
      hold_r      <= '0;
      idle_r      <= '0;
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
      field_r     <= 2'd0;
      run_en_r    <= 1'b1;
      pulse_r     <= 6'b000000;
    end else begin
      state_r     <= state_nx_s;
      ret_r       <= ret_nx_s;
      mode_q_r    <= bus.btn_mode;
      up_q_r      <= bus.btn_up;
      down_q_r    <= bus.btn_down;
      hold_r      <= hold_nx_s;
      idle_r      <= idle_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      blink_r     <= blink_nx_s;
      field_r     <= field_nx_s;
      run_en_r    <= (state_nx_s == RUN);
      pulse_r     <= pulse_nx_s;
    end
  end

  assign bus.field    = field_r;
  assign bus.run_en   = run_en_r;
  assign bus.blink    = blink_r;
  assign bus.day_inc  = pulse_r[P_DI];
  assign bus.day_dec  = pulse_r[P_DD];
  assign bus.mon_inc  = pulse_r[P_MI];
  assign bus.mon_dec  = pulse_r[P_MD];
  assign bus.year_inc = pulse_r[P_YI];
  assign bus.year_dec = pulse_r[P_YD];

endmodule

// File: tb/tb_date_edit_ctrl.sv
// Directed bench for date_edit_ctrl with a small day/month/leap counter stand-in
// that reacts to the DUT's pulses.
module tb_date_edit_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  date_edit_ctrl_if ifc();

  date_edit_ctrl #(
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2),
    .TIMEOUT     (20),
    .BLINK_HALF  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  logic       load = 1'b1;
  logic [4:0] ld_day = 5'd15;
  logic [3:0] ld_mon = 4'd6;
  logic       ld_leap = 1'b0;
  logic [4:0] day_m;
  logic [3:0] mon_m;
  logic       leap_m;

  // Counter-chain stand-in: a year step always lands on a non-leap year here.
  always @(posedge clk) begin
    if (load) begin
      day_m  <= ld_day;
      mon_m  <= ld_mon;
      leap_m <= ld_leap;
    end else begin
      if (ifc.day_inc) day_m <= day_m + 5'd1;
      else if (ifc.day_dec) day_m <= day_m - 5'd1;
      if (ifc.mon_inc) mon_m <= mon_m + 4'd1;
      else if (ifc.mon_dec) mon_m <= mon_m - 4'd1;
      if (ifc.year_inc || ifc.year_dec) leap_m <= 1'b0;
    end
  end

  assign ifc.day_value   = day_m;
  assign ifc.month_value = mon_m;
  assign ifc.leap        = leap_m;

  int checks = 0;
  int passed = 0;
  int n_di, n_dd, n_mi, n_md, n_yi, n_yd;
  logic [11:0] pat;

  function automatic logic [9:0] out_vec();
    return {ifc.field, ifc.run_en, ifc.blink, ifc.day_inc, ifc.day_dec,
            ifc.mon_inc, ifc.mon_dec, ifc.year_inc, ifc.year_dec};
  endfunction

  task automatic clr();
    n_di = 0; n_dd = 0; n_mi = 0; n_md = 0; n_yi = 0; n_yd = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    n_di += int'(ifc.day_inc);  n_dd += int'(ifc.day_dec);
    n_mi += int'(ifc.mon_inc);  n_md += int'(ifc.mon_dec);
    n_yi += int'(ifc.year_inc); n_yd += int'(ifc.year_dec);
  endtask

  task automatic press_mode();
    ifc.btn_mode = 1'b1; cyc();
    ifc.btn_mode = 1'b0; cyc();
  endtask

  task automatic do_load(input logic [4:0] d, input logic [3:0] m, input logic l);
    ld_day = d; ld_mon = m; ld_leap = l;
    load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== 10'b00_1_0_000000) $display("FAIL reset_outputs got=%b want=%b", out_vec(), 10'b0010000000);
    else passed++;
    rst_n = 1'b1; load = 1'b0;
    cyc();
  endtask

  task automatic test_mode_seq();
    clr();
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd1) $display("FAIL mode_field1 got=%0d want=1", ifc.field); else passed++;
    checks++; if (ifc.run_en !== 1'b0) $display("FAIL mode_run_en0 got=%b want=0", ifc.run_en); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    checks++; if (ifc.blink !== 1'b0) $display("FAIL blink_tick1 got=%b want=0", ifc.blink); else passed++;
    cyc(); cyc();
    checks++; if (ifc.blink !== 1'b1) $display("FAIL blink_tick3 got=%b want=1", ifc.blink); else passed++;
    repeat (3) cyc();
    checks++; if (ifc.blink !== 1'b0) $display("FAIL blink_tick6 got=%b want=0", ifc.blink); else passed++;
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd2) $display("FAIL mode_field2 got=%0d want=2", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd3) $display("FAIL mode_field3 got=%0d want=3", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd0) $display("FAIL mode_field0 got=%0d want=0", ifc.field); else passed++;
    checks++; if (ifc.run_en !== 1'b1) $display("FAIL mode_run_en1 got=%b want=1", ifc.run_en); else passed++;
    checks++; if (ifc.blink !== 1'b0) $display("FAIL mode_blink_run got=%b want=0", ifc.blink); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    checks++;
    if (n_di + n_dd + n_mi + n_md + n_yi + n_yd !== 0) $display("FAIL mode_no_pulses got=%0d want=0", n_di + n_dd + n_mi + n_md + n_yi + n_yd);
    else passed++;
  endtask

  task automatic test_single();
    do_load(5'd15, 4'd6, 1'b0);
    press_mode(); press_mode(); press_mode();
    clr();
    ifc.btn_up = 1'b1; cyc();
    checks++; if (ifc.year_inc !== 1'b1) $display("FAIL single_year_inc got=%b want=1", ifc.year_inc); else passed++;
    ifc.btn_up = 1'b0; cyc();
    checks++; if (ifc.year_inc !== 1'b0) $display("FAIL single_pulse_width got=%b want=0", ifc.year_inc); else passed++;
    repeat (6) cyc();
    checks++; if (n_yi !== 1) $display("FAIL single_year_inc_count got=%0d want=1", n_yi); else passed++;
    checks++;
    if (n_di + n_dd + n_mi + n_md + n_yd !== 0) $display("FAIL single_other_pulses got=%0d want=0", n_di + n_dd + n_mi + n_md + n_yd);
    else passed++;
    checks++; if (ifc.field !== 2'd3) $display("FAIL single_field got=%0d want=3", ifc.field); else passed++;
    clr();
    ifc.btn_up = 1'b1; ifc.btn_down = 1'b1;
    repeat (8) cyc();
    ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; cyc();
    checks++;
    if (n_yi + n_yd !== 0) $display("FAIL both_buttons got=%0d want=0", n_yi + n_yd);
    else passed++;
    clr();
    ifc.btn_mode = 1'b1; ifc.btn_up = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd0) $display("FAIL mode_beats_up_field got=%0d want=0", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; ifc.btn_up = 1'b0; cyc(); cyc();
    checks++;
    if (n_di + n_dd + n_mi + n_md + n_yi + n_yd !== 0) $display("FAIL mode_beats_up_pulses got=%0d want=0", n_di + n_dd + n_mi + n_md + n_yi + n_yd);
    else passed++;
  endtask

  task automatic test_auto_repeat();
    press_mode();
    do_load(5'd15, 4'd6, 1'b0);
    clr();
    ifc.btn_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      pat[i] = ifc.day_dec;
    end
    checks++; if (pat !== 12'h551) $display("FAIL repeat_pattern got=%h want=551", pat); else passed++;
    ifc.btn_down = 1'b0;
    clr();
    repeat (6) cyc();
    checks++; if (n_dd + n_di !== 0) $display("FAIL repeat_release got=%0d want=0", n_dd + n_di); else passed++;
    checks++; if (day_m !== 5'd10) $display("FAIL repeat_day got=%0d want=10", day_m); else passed++;
  endtask

  task automatic test_clamp_month();
    press_mode();
    do_load(5'd31, 4'd1, 1'b0);
    clr();
    ifc.btn_up = 1'b1; cyc();
    checks++; if (ifc.mon_inc !== 1'b1) $display("FAIL clamp_mon_inc got=%b want=1", ifc.mon_inc); else passed++;
    ifc.btn_up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      pat[i] = ifc.day_dec;
    end
    checks++; if (pat !== 12'h02A) $display("FAIL clamp28_pattern got=%h want=02a", pat); else passed++;
    checks++; if (day_m !== 5'd28) $display("FAIL clamp28_day got=%0d want=28", day_m); else passed++;
    checks++; if (mon_m !== 4'd2) $display("FAIL clamp28_month got=%0d want=2", mon_m); else passed++;
    checks++; if (ifc.field !== 2'd2) $display("FAIL clamp28_field got=%0d want=2", ifc.field); else passed++;
    do_load(5'd31, 4'd1, 1'b1);
    ifc.btn_up = 1'b1; cyc();
    ifc.btn_up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      pat[i] = ifc.day_dec;
    end
    checks++; if (pat !== 12'h00A) $display("FAIL clamp29_pattern got=%h want=00a", pat); else passed++;
    checks++; if (day_m !== 5'd29) $display("FAIL clamp29_day got=%0d want=29", day_m); else passed++;
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd3) $display("FAIL clamp_back_in_emon got=%0d want=3", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; cyc();
  endtask

  task automatic test_clamp_year();
    do_load(5'd29, 4'd2, 1'b1);
    clr();
    ifc.btn_up = 1'b1; cyc();
    checks++; if (ifc.year_inc !== 1'b1) $display("FAIL year_clamp_inc got=%b want=1", ifc.year_inc); else passed++;
    ifc.btn_up = 1'b0; ifc.btn_mode = 1'b1; cyc();
    ifc.btn_mode = 1'b0;
    repeat (8) cyc();
    checks++; if (n_dd !== 1) $display("FAIL year_clamp_dec_count got=%0d want=1", n_dd); else passed++;
    checks++; if (day_m !== 5'd28) $display("FAIL year_clamp_day got=%0d want=28", day_m); else passed++;
    checks++; if (ifc.field !== 2'd3) $display("FAIL year_clamp_mode_ignored got=%0d want=3", ifc.field); else passed++;
  endtask

  task automatic test_timeout();
    press_mode(); press_mode();
    ifc.btn_mode = 1'b1; cyc();
    ifc.btn_mode = 1'b0; cyc();
    repeat (18) cyc();
    checks++; if (ifc.field !== 2'd2) $display("FAIL timeout_early got=%0d want=2", ifc.field); else passed++;
    checks++; if (ifc.run_en !== 1'b0) $display("FAIL timeout_early_run_en got=%b want=0", ifc.run_en); else passed++;
    cyc();
    checks++; if (ifc.field !== 2'd0) $display("FAIL timeout_field got=%0d want=0", ifc.field); else passed++;
    checks++; if (ifc.run_en !== 1'b1) $display("FAIL timeout_run_en got=%b want=1", ifc.run_en); else passed++;
    checks++; if (ifc.blink !== 1'b0) $display("FAIL timeout_blink got=%b want=0", ifc.blink); else passed++;
  endtask

  task automatic test_reset_hold();
    press_mode();
    ifc.btn_mode = 1'b1; rst_n = 1'b0; #1;
    checks++; if (ifc.field !== 2'd0) $display("FAIL async_reset_field got=%0d want=0", ifc.field); else passed++;
    checks++; if (ifc.run_en !== 1'b1) $display("FAIL async_reset_run_en got=%b want=1", ifc.run_en); else passed++;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    checks++; if (ifc.field !== 2'd0) $display("FAIL held_through_reset got=%0d want=0", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    ifc.btn_mode = 1'b1; cyc();
    checks++; if (ifc.field !== 2'd1) $display("FAIL repress_after_reset got=%0d want=1", ifc.field); else passed++;
    ifc.btn_mode = 1'b0; cyc();
    press_mode();
    do_load(5'd31, 4'd1, 1'b0);
    ifc.btn_up = 1'b1; cyc();
    clr();
    ifc.btn_up = 1'b0; rst_n = 1'b0; #1;
    checks++; if (out_vec() !== 10'b00_1_0_000000) $display("FAIL clamp_reset_outputs got=%b want=%b", out_vec(), 10'b0010000000); else passed++;
    repeat (6) cyc();
    checks++; if (n_dd !== 0) $display("FAIL clamp_reset_no_dec got=%0d want=0", n_dd); else passed++;
    rst_n = 1'b1; cyc();
  endtask

  initial begin
    ifc.tick = 1'b1;
    ifc.btn_mode = 1'b0;
    ifc.btn_up = 1'b0;
    ifc.btn_down = 1'b0;
    clr();
    test_reset();
    test_mode_seq();
    test_single();
    test_auto_repeat();
    test_clamp_month();
    test_clamp_year();
    test_timeout();
    test_reset_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d passed=%0d", checks, passed);
    $fatal(1, "bench time limit");
  end
endmodule
